reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the "clocks stable" level from the counter-based delay generator and releases
//  NUM_DOMAINS active-low domain resets one at a time, GAP_CYCLES apart, bit 0 first.
//  Sits between the delay generator and the per-domain reset synchronisers in the CRG.
//  Supports software re-sequencing and aborts cleanly when the upstream ready drops.
// PARAMETERS
//  NUM_DOMAINS  4    number of reset domains sequenced (>=1)
//  GAP_CYCLES   16   cycles between successive releases, also re-assert hold time (>=1)
//  ACK_TIMEOUT  255  max cycles waiting for a domain ack (used only with RESET_SEQ_ACK_EN)
// PORTS
//  clk_i      in   1            clock
//  srst_i     in   1            synchronous reset, active-high
//  ready_i    in   1            level from delay generator; 1 = clocks stable
//  sw_rst_i   in   1            single-cycle request to re-assert and re-run the sequence
//  ack_i      in   NUM_DOMAINS  per-domain "out of reset" ack (ignored without macro)
//  rst_no     out  NUM_DOMAINS  domain resets, active-low, registered
//  busy_o     out  1            sequence in progress (WAIT_GAP/WAIT_ACK/ASSERT)
//  done_o     out  1            all domains released
//  err_o      out  1            sticky ack timeout flag (tied 0 without macro)
// BEHAVIOUR
//  - One clock: clk_i. Reset is synchronous and active-high: srst_i, sampled on clk_i rising edge.
//  - srst_i has top priority: next edge -> state IDLE, rst_no='0, busy_o=0, done_o=0, err_o=0,
//    counter=0, index=0. Applies mid-sequence as well.
//  - All outputs registered. "At edge k" means the output value updates on that edge.
//  - States: IDLE, WAIT_GAP, WAIT_ACK (macro only), DONE, ASSERT.
//  - IDLE: rst_no='0, busy_o=0. ready_i sampled 1 at edge k -> WAIT_GAP, counter=0, index=0,
//    busy_o=1 at k. sw_rst_i is ignored in IDLE.
//  - WAIT_GAP: counter increments each cycle. At the edge where counter reaches GAP_CYCLES, set
//    rst_no[index] to 1 and clear the counter. Without the macro, domain i releases at edge
//    k+(i+1)*GAP_CYCLES. After the last domain: enter DONE, and done_o=1 on the same edge
//    as rst_no[NUM_DOMAINS-1]; busy_o=0.
//  - Released bits stay 1 until an abort, sw_rst_i or srst_i. Bits are never released out of order.
//  - Abort: ready_i sampled 0 in any non-IDLE state (including ASSERT) -> next edge rst_no='0,
//    done_o=0, busy_o=0, state IDLE. The sequence restarts from domain 0 when ready_i returns.
//    Abort has priority over sw_rst_i.
//  - sw_rst_i sampled 1 in WAIT_GAP, WAIT_ACK or DONE, with ready_i=1 -> next edge rst_no='0,
//    done_o=0, busy_o=1, state ASSERT, counter=0, err_o cleared.
//  - ASSERT: hold rst_no='0 for GAP_CYCLES cycles, then go to IDLE. Restart follows the IDLE
//    rule, so a re-run adds one IDLE sample cycle. sw_rst_i is ignored during ASSERT.
//  - GAP_CYCLES=1: domains release on consecutive edges.
//  - NUM_DOMAINS=1: done_o rises with rst_no[0].
//  - Counter width: $clog2(max(GAP_CYCLES,ACK_TIMEOUT)+1). Index width: $clog2(NUM_DOMAINS+1).
//    No wrap is possible; the counter is cleared on every state change.
// CONFIGURATION
//  - Macro RESET_SEQ_ACK_EN.
//  - Defined: after releasing domain i (i<NUM_DOMAINS-1), enter WAIT_ACK.
//    - ack_i[i] sampled 1 at edge a -> WAIT_GAP, counter=0; domain i+1 releases at a+GAP_CYCLES.
//    - No ack within ACK_TIMEOUT cycles -> err_o=1 (sticky) and continue to WAIT_GAP anyway.
//    - The last domain needs no ack.
//    - err_o is cleared only by srst_i or an accepted sw_rst_i.
//  - Undefined: no WAIT_ACK state, ack_i unused, err_o tied 0, timing as in WAIT_GAP above.
// TESTING  (NUM_DOMAINS=4, GAP_CYCLES=8, ACK_TIMEOUT=20)
//  1. srst_i 2 cycles, ready_i=0 for 50 cycles -> rst_no=4'b0000, busy_o=0, done_o=0 throughout.
//  2. ready_i=1 first sampled at edge k -> rst_no 0001@k+8, 0011@k+16, 0111@k+24,
//     1111@k+32 with done_o=1@k+32; busy_o=1 from k to k+31.
//  3. ready_i=0 at k+20 -> rst_no=0000, busy_o=0 at k+21. ready_i=1 sampled at edge j ->
//     rst_no 0001@j+8.
//  4. In DONE, sw_rst_i pulse sampled at edge m -> rst_no=0000, done_o=0 at m+1; rst_no stays 0
//     through m+9; resequence gives 0001 at m+18.
//  5. srst_i at k+12 (after 0001) -> all outputs at reset values at k+13; no release while srst_i=1.
//  6. RESET_SEQ_ACK_EN: ack_i=0 -> err_o=1 20 cycles after 0001, 0011 8 cycles later.
//     ack_i[0] at 3 cycles -> err_o stays 0. sw_rst_i clears err_o.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the CRG delay generator, software and the reset sequencer.
// The slave modport is the sequencer side; master is the driver/observer side.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   ready_i;
  logic                   sw_rst_i;
  logic [NUM_DOMAINS-1:0] ack_i;
  logic [NUM_DOMAINS-1:0] rst_no;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;

  modport master (
    output ready_i, sw_rst_i, ack_i,
    input  rst_no, busy_o, done_o, err_o
  );

  modport slave (
    input  ready_i, sw_rst_i, ack_i,
    output rst_no, busy_o, done_o, err_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases active-low domain resets in order, GAP_CYCLES apart, once clocks are stable.
// Define RESET_SEQ_ACK_EN to wait for a per-domain ack (with timeout) between releases.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input logic              clk_i,
  input logic              srst_i,
  reset_sequencer_if.slave bus
);
  localparam int MAXC = (GAP_CYCLES > ACK_TIMEOUT) ?
                        GAP_CYCLES : ACK_TIMEOUT;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE = NUM_DOMAINS'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GAP    = 3'd1;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ASSERT = 3'd4;
`ifdef RESET_SEQ_ACK_EN
  localparam logic [2:0] ST_ACK    = 3'd2;
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
`endif

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sw_ok;

`ifdef RESET_SEQ_ACK_EN
  logic                   err_q, err_d;
  logic [NUM_DOMAINS-1:0] last_rel;

  // Releases are thermometer coded, so the top set bit is the latest domain.
  assign last_rel = rst_q & ~(rst_q >> 1);
  assign sw_ok    = (state_q == ST_GAP) || (state_q == ST_ACK) ||
                    (state_q == ST_DONE);
`else
  logic unused_ack;

  assign unused_ack = ^bus.ack_i;
  assign sw_ok      = (state_q == ST_GAP) || (state_q == ST_DONE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef RESET_SEQ_ACK_EN
    err_d   = err_q;
`endif
    if (state_q != ST_IDLE && !bus.ready_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (bus.sw_rst_i && sw_ok) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`ifdef RESET_SEQ_ACK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          rst_d = '0;
          if (bus.ready_i) begin
            state_d = ST_GAP;
            busy_d  = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            rst_d = (rst_q << 1) | ONE;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
`ifdef RESET_SEQ_ACK_EN
            else state_d = ST_ACK;
`endif
          end
        end
`ifdef RESET_SEQ_ACK_EN
        ST_ACK: begin
          if (|(bus.ack_i & last_rel)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else if (cnt_q == ACK_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
`endif
        ST_DONE: cnt_d = '0;
        ST_ASSERT: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RESET_SEQ_ACK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.rst_no = rst_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
`ifdef RESET_SEQ_ACK_EN
  assign bus.err_o  = err_q;
`else
  assign bus.err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: per-edge expectations are queued from the
// release timeline, then popped and compared one time unit after each rising edge.
module tb_reset_sequencer;
  localparam int ND  = 4;
  localparam int GAP = 8;
  localparam int TO  = 20;
`ifdef RESET_SEQ_ACK_EN
  localparam int EX = 1;
`else
  localparam int EX = 0;
`endif

  typedef struct {
    int       at;
    logic [3:0] rst;
    logic     busy;
    logic     done;
    logic     err;
  } exp_t;

  logic clk = 1'b0;
  logic srst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS(ND),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .srst_i(srst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int e, input logic [3:0] r, input logic b,
                      input logic d, input logic er);
    sb.push_back('{at: e, rst: r, busy: b, done: d, err: er});
  endtask

  task automatic push_flat(input int from, input int to, input logic [3:0] r,
                           input logic b, input logic d, input logic er);
    for (int e = from; e <= to; e++) push(e, r, b, d, er);
  endtask

  // Full sequence started at edge k with acks (if any) returned immediately.
  task automatic push_seq(input int k, input int last);
    for (int e = k; e <= last; e++) begin
      int n = 0;
      for (int i = 0; i < ND; i++)
        if (e >= k + (i + 1) * GAP + i * EX) n++;
      push(e, 4'((1 << n) - 1), n != ND, n == ND, 1'b0);
    end
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      x = sb.pop_front();
      if (x.at != cyc) chk("late", cyc, x.at);
      chk($sformatf("rst_no@%0d", x.at), 32'(bus.rst_no), 32'(x.rst));
      chk($sformatf("busy@%0d", x.at), 32'(bus.busy_o), 32'(x.busy));
      chk($sformatf("done@%0d", x.at), 32'(bus.done_o), 32'(x.done));
      chk($sformatf("err@%0d", x.at), 32'(bus.err_o), 32'(x.err));
    end
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  initial begin
    int k, m, d, k2, j, j2, r0;
    srst         = 1'b1;
    bus.ready_i  = 1'b0;
    bus.sw_rst_i = 1'b0;
    bus.ack_i    = '1;

    // reset, then ready low for 50 cycles
    push_flat(1, 52, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    srst = 1'b0;
    run_to(52);

    // first full sequence
    bus.ready_i = 1'b1;
    k = 53;
    push_seq(k, k + 36 + 3 * EX);
    run_to(k + 36 + 3 * EX);

    // software re-sequence from DONE; a second pulse during ASSERT is ignored
    m = cyc;
    push_flat(m + 1, m + 8, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_flat(m + 9, m + 9, 4'b0000, 1'b0, 1'b0, 1'b0);
    push_seq(m + 10, m + 46 + 3 * EX);
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    tick();
    tick();
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    run_to(m + 46 + 3 * EX);

    // abort from DONE, restart, abort mid-sequence, restart
    d = cyc;
    push_flat(d + 1, d + 2, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.ready_i = 1'b0;
    run_to(d + 2);
    bus.ready_i = 1'b1;
    k2 = d + 3;
    push_seq(k2, k2 + 20);
    push_flat(k2 + 21, k2 + 22, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_to(k2 + 20);
    bus.ready_i = 1'b0;
    run_to(k2 + 22);
    bus.ready_i = 1'b1;
    j = k2 + 23;
    push_seq(j, j + 12);
    run_to(j + 12);

    // synchronous reset mid-sequence
    push_flat(j + 13, j + 16, 4'b0000, 1'b0, 1'b0, 1'b0);
    srst = 1'b1;
    run_to(j + 16);
    srst = 1'b0;
    j2 = j + 17;

`ifdef RESET_SEQ_ACK_EN
    // late ack on domain 0, then timeouts on domains 1 and 2
    bus.ack_i = '0;
    r0 = j2 + GAP;
    push_flat(j2,      r0 - 1,  4'b0000, 1'b1, 1'b0, 1'b0);
    push_flat(r0,      r0 + 10, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_flat(r0 + 11, r0 + 30, 4'b0011, 1'b1, 1'b0, 1'b0);
    push_flat(r0 + 31, r0 + 38, 4'b0011, 1'b1, 1'b0, 1'b1);
    push_flat(r0 + 39, r0 + 66, 4'b0111, 1'b1, 1'b0, 1'b1);
    push_flat(r0 + 67, r0 + 69, 4'b1111, 1'b0, 1'b1, 1'b1);
    push_flat(r0 + 70, r0 + 72, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_to(r0 + 2);
    bus.ack_i = 4'b0001;
    tick();
    bus.ack_i = '0;
    run_to(r0 + 69);
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    run_to(r0 + 72);
`else
    r0 = j2;
    push_seq(r0, r0 + 36);
    run_to(r0 + 36);
`endif

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
